// File: rtl/state_seq.sv
// State sequencer: walks a one-hot machine state through ENTRY/MEMWAIT/S1/GAP/S2/GOT
// phases, emitting strobes, a memory request with timeout alarm, and enable-driven successors.
module state_seq #(
  parameter int STROB_GAP   = 1,
  parameter int ALARM_TICKS = 16
) (
  input  logic __clk,
  input  logic clo,
  input  logic ep0,
  input  logic ep1,
  input  logic ep2,
  input  logic ep3,
  input  logic ep4,
  input  logic ep5,
  input  logic ek1,
  input  logic ek2,
  input  logic ewx,
  input  logic stp0,
  input  logic ok,
  output logic p0,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p5,
  output logic k1,
  output logic k2,
  output logic wx,
  output logic strob1,
  output logic strob2,
  output logic got,
  output logic mem_rq,
  output logic alarm
);

  typedef enum logic [3:0] {
    ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_K1, ST_K2, ST_WX
  } state_e;

  typedef enum logic [2:0] {
    PH_ENTRY, PH_MEMWAIT, PH_S1, PH_GAP, PH_S2, PH_ALARM, PH_GOT
  } phase_e;

  localparam logic [7:0] WAIT_LAST = 8'(ALARM_TICKS - 1);
  localparam logic [2:0] GAP_LAST  = 3'(STROB_GAP - 1);

  state_e     state_q, state_d, sel_state;
  phase_e     phase_q, phase_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic       timeout_q, timeout_d;
  logic [8:0] state_oh_q, state_oh_d;
  logic [4:0] pulse_q, pulse_d;

  // Fixed-priority successor choice; only consulted in GOT.
  always_comb begin
    sel_state = ST_P0;
    if      (ek2) sel_state = ST_K2;
    else if (ek1) sel_state = ST_K1;
    else if (ep0) sel_state = ST_P0;
    else if (ep5) sel_state = ST_P5;
    else if (ep4) sel_state = ST_P4;
    else if (ep3) sel_state = ST_P3;
    else if (ep2) sel_state = ST_P2;
    else if (ep1) sel_state = ST_P1;
    else if (ewx) sel_state = ST_WX;
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = timeout_q;
    case (phase_q)
      PH_ENTRY: begin
        wait_cnt_d = '0;
        gap_cnt_d  = '0;
        timeout_d  = 1'b0;
        if (state_q == ST_P1 || state_q == ST_P2) phase_d = PH_MEMWAIT;
        else if (state_q != ST_P0 || stp0)        phase_d = PH_S1;
      end
      PH_MEMWAIT: begin
        // An ok in the final wait cycle still beats the timeout.
        if (ok) begin
          phase_d = PH_S1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          phase_d   = PH_ALARM;
          timeout_d = 1'b1;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      PH_S1: begin
        gap_cnt_d = '0;
        phase_d   = (STROB_GAP == 0) ? PH_S2 : PH_GAP;
      end
      PH_GAP: begin
        if (gap_cnt_q == GAP_LAST) phase_d = PH_S2;
        else                       gap_cnt_d = gap_cnt_q + 3'd1;
      end
      PH_S2:    phase_d = PH_GOT;
      PH_ALARM: phase_d = PH_GOT;
      PH_GOT: begin
        phase_d = PH_ENTRY;
        state_d = timeout_q ? ST_P0 : sel_state;
      end
      default:  phase_d = PH_ENTRY;
    endcase
  end

  // Outputs are registered copies of the decoded next state/phase.
  always_comb begin
    state_oh_d = {state_d == ST_P0, state_d == ST_P1, state_d == ST_P2,
                  state_d == ST_P3, state_d == ST_P4, state_d == ST_P5,
                  state_d == ST_K1, state_d == ST_K2, state_d == ST_WX};
    pulse_d    = {phase_d == PH_S1, phase_d == PH_S2, phase_d == PH_GOT,
                  phase_d == PH_MEMWAIT, phase_d == PH_ALARM};
  end

  always_ff @(posedge __clk) begin
    if (clo) begin
      state_q    <= ST_P0;
      phase_q    <= PH_ENTRY;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      state_oh_q <= 9'b1_0000_0000;
      pulse_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      timeout_q  <= timeout_d;
      state_oh_q <= state_oh_d;
      pulse_q    <= pulse_d;
    end
  end

  assign {p0, p1, p2, p3, p4, p5, k1, k2, wx} = state_oh_q;
  assign {strob1, strob2, got, mem_rq, alarm}  = pulse_q;

endmodule

// File: tb/tb_state_seq.sv
// Directed bench for state_seq: default instance (gap 1, 16 alarm ticks) and a gap-0 instance,
// with per-cycle one-hot and once-per-visit pulse monitors.
module tb_state_seq;

  localparam int P0 = 0, P1 = 1, P2 = 2, P3 = 3, P4 = 4, K1 = 6, K2 = 7;
  localparam logic [4:0] N = 5'b00000, S1P = 5'b10000, S2P = 5'b01000,
                         GP = 5'b00100, MP = 5'b00010, AP = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clo, ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ewx, stp0, ok;
  logic p0, p1, p2, p3, p4, p5, k1, k2, wx, strob1, strob2, got, mem_rq, alarm;
  logic g_clo, g_ep3, g_stp0, g_ok;
  logic g_p0, g_p1, g_p2, g_p3, g_p4, g_p5, g_k1, g_k2, g_wx;
  logic g_strob1, g_strob2, g_got, g_mem_rq, g_alarm;
  logic [13:0] obs, g_obs;
  int n_cmp = 0, n_err = 0;
  bit mon_on = 0;

  assign obs   = {p0, p1, p2, p3, p4, p5, k1, k2, wx, strob1, strob2, got, mem_rq, alarm};
  assign g_obs = {g_p0, g_p1, g_p2, g_p3, g_p4, g_p5, g_k1, g_k2, g_wx,
                  g_strob1, g_strob2, g_got, g_mem_rq, g_alarm};

  state_seq dut (
    .__clk(clk), .clo(clo), .ep0(ep0), .ep1(ep1), .ep2(ep2), .ep3(ep3), .ep4(ep4),
    .ep5(ep5), .ek1(ek1), .ek2(ek2), .ewx(ewx), .stp0(stp0), .ok(ok),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .k1(k1), .k2(k2), .wx(wx),
    .strob1(strob1), .strob2(strob2), .got(got), .mem_rq(mem_rq), .alarm(alarm)
  );

  state_seq #(.STROB_GAP(0), .ALARM_TICKS(16)) dut_g0 (
    .__clk(clk), .clo(g_clo), .ep0(1'b0), .ep1(1'b0), .ep2(1'b0), .ep3(g_ep3), .ep4(1'b0),
    .ep5(1'b0), .ek1(1'b0), .ek2(1'b0), .ewx(1'b0), .stp0(g_stp0), .ok(g_ok),
    .p0(g_p0), .p1(g_p1), .p2(g_p2), .p3(g_p3), .p4(g_p4), .p5(g_p5), .k1(g_k1), .k2(g_k2),
    .wx(g_wx), .strob1(g_strob1), .strob2(g_strob2), .got(g_got), .mem_rq(g_mem_rq),
    .alarm(g_alarm)
  );

  function automatic logic [13:0] ev(input int st, input logic [4:0] pl);
    logic [8:0] oh;
    oh = 9'h100 >> st;
    return {oh, pl};
  endfunction

  task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [13:0] e);
    @(posedge clk); #1;
    chk(tag, obs, e);
  endtask

  task automatic gcyc(input string tag, input logic [13:0] e);
    @(posedge clk); #1;
    chk(tag, g_obs, e);
  endtask

  task automatic visit_chk(input string tag, input logic [8:0] st, input int a,
                           input int b, input int c);
    n_cmp++;
    assert ($onehot(st)) else begin
      n_err++;
      $error("FAIL %s_onehot: observed %b expected one bit set", tag, st);
    end
    n_cmp++;
    assert (a <= 1 && b <= 1 && c <= 1) else begin
      n_err++;
      $error("FAIL %s_pulses: observed s1=%0d s2=%0d got=%0d expected each <= 1", tag, a, b, c);
    end
  endtask

  // Per-cycle monitors; a visit starts after a GOT cycle or a reset cycle.
  initial begin
    int s1 = 0, s2 = 0, gt = 0;
    logic got_prev = 1'b1, clo_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (got_prev || clo_prev) begin s1 = 0; s2 = 0; gt = 0; end
        s1 += int'(strob1); s2 += int'(strob2); gt += int'(got);
        visit_chk("main", obs[13:5], s1, s2, gt);
        got_prev = got;
        clo_prev = clo;
      end
    end
  end

  initial begin
    int s1 = 0, s2 = 0, gt = 0;
    logic got_prev = 1'b1, clo_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (got_prev || clo_prev) begin s1 = 0; s2 = 0; gt = 0; end
        s1 += int'(g_strob1); s2 += int'(g_strob2); gt += int'(g_got);
        visit_chk("gap0", g_obs[13:5], s1, s2, gt);
        got_prev = g_got;
        clo_prev = g_clo;
      end
    end
  end

  initial begin
    {ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ewx, ok} = '0;
    {g_ep3, g_stp0, g_ok} = '0;
    clo = 1'b1; g_clo = 1'b1; stp0 = 1'b1;
    cyc("rst_0", ev(P0, N));
    cyc("rst_hold_stp0", ev(P0, N));
    gcyc("g_rst", ev(P0, N));
    clo = 1'b0; g_clo = 1'b0; stp0 = 1'b0;
    mon_on = 1;
    cyc("idle_p0", ev(P0, N));

    // P0 start, into memory state P1 with ok after three wait cycles
    stp0 = 1'b1;
    cyc("a_c1_s1", ev(P0, S1P)); stp0 = 1'b0;
    cyc("a_c2_gap", ev(P0, N));
    cyc("a_c3_s2", ev(P0, S2P));
    cyc("a_c4_got", ev(P0, GP)); ep1 = 1'b1;
    cyc("a_c5_p1", ev(P1, N)); ep1 = 1'b0;
    cyc("a_c6_mem", ev(P1, MP));
    cyc("a_c7_mem", ev(P1, MP));
    cyc("a_c8_mem", ev(P1, MP)); ok = 1'b1;
    cyc("a_c9_s1", ev(P1, S1P)); ok = 1'b0;
    cyc("a_c10_gap", ev(P1, N)); ok = 1'b1;
    cyc("a_c11_s2", ev(P1, S2P)); ok = 1'b0;
    cyc("a_c12_got", ev(P1, GP)); ep4 = 1'b1;
    cyc("a_p4_entry", ev(P4, N)); ep4 = 1'b0;
    cyc("a_p4_s1", ev(P4, S1P));
    cyc("a_p4_gap", ev(P4, N));
    cyc("a_p4_s2", ev(P4, S2P)); clo = 1'b1;
    cyc("a_rst_mid", ev(P0, N)); clo = 1'b0;
    repeat (10) cyc("a_no_stp0", ev(P0, N));

    // P1 timeout: alarm, then forced P0 despite ep3
    stp0 = 1'b1;
    cyc("b_s1", ev(P0, S1P)); stp0 = 1'b0;
    cyc("b_gap", ev(P0, N));
    cyc("b_s2", ev(P0, S2P));
    cyc("b_got", ev(P0, GP)); ep1 = 1'b1;
    cyc("b_p1", ev(P1, N)); ep1 = 1'b0;
    repeat (16) cyc("b_memwait", ev(P1, MP));
    cyc("b_alarm", ev(P1, AP)); ep3 = 1'b1;
    cyc("b_got_after_alarm", ev(P1, GP));
    cyc("b_forced_p0", ev(P0, N)); ep3 = 1'b0;

    // P2 with ok in the final wait cycle, then priority checks
    stp0 = 1'b1;
    cyc("c_s1", ev(P0, S1P)); stp0 = 1'b0;
    cyc("c_gap", ev(P0, N));
    cyc("c_s2", ev(P0, S2P));
    cyc("c_got", ev(P0, GP)); ep2 = 1'b1;
    cyc("c_p2", ev(P2, N)); ep2 = 1'b0;
    repeat (16) cyc("c_memwait", ev(P2, MP));
    ok = 1'b1;
    cyc("c_ok_last_wins", ev(P2, S1P)); ok = 1'b0;
    cyc("c_gap2", ev(P2, N));
    cyc("c_s2_2", ev(P2, S2P));
    cyc("c_got2", ev(P2, GP)); {ep1, ep4, ewx, ek1} = 4'b1111;
    cyc("c_prio_k1", ev(K1, N)); {ep1, ep4, ewx, ek1} = 4'b0000; ep5 = 1'b1;
    cyc("c_k1_s1", ev(K1, S1P));
    cyc("c_k1_gap", ev(K1, N)); ep5 = 1'b0;
    cyc("c_k1_s2", ev(K1, S2P));
    cyc("c_k1_got", ev(K1, GP)); {ep1, ewx} = 2'b11;
    cyc("c_prio_p1", ev(P1, N)); {ep1, ewx} = 2'b00;
    cyc("c_p1_mem", ev(P1, MP)); ok = 1'b1;
    cyc("c_p1_s1", ev(P1, S1P)); ok = 1'b0;
    cyc("c_p1_gap", ev(P1, N));
    cyc("c_p1_s2", ev(P1, S2P));
    cyc("c_p1_got", ev(P1, GP));
    cyc("c_none_p0", ev(P0, N));

    // P0 re-entry restarts at ENTRY; ek2 outranks ek1 and ep0
    stp0 = 1'b1;
    cyc("d_s1", ev(P0, S1P)); stp0 = 1'b0;
    cyc("d_gap", ev(P0, N));
    cyc("d_s2", ev(P0, S2P));
    cyc("d_got", ev(P0, GP)); ep0 = 1'b1;
    cyc("d_reenter_p0", ev(P0, N)); ep0 = 1'b0;
    cyc("d_p0_hold", ev(P0, N)); stp0 = 1'b1;
    cyc("d2_s1", ev(P0, S1P)); stp0 = 1'b0;
    cyc("d2_gap", ev(P0, N));
    cyc("d2_s2", ev(P0, S2P));
    cyc("d2_got", ev(P0, GP)); {ek2, ek1, ep0} = 3'b111;
    cyc("d_prio_k2", ev(K2, N)); {ek2, ek1, ep0} = 3'b000;
    cyc("d_k2_s1", ev(K2, S1P));
    cyc("d_k2_gap", ev(K2, N));
    cyc("d_k2_s2", ev(K2, S2P));
    cyc("d_k2_got", ev(K2, GP));
    cyc("d_k2_to_p0", ev(P0, N));

    // Gap-0 instance: P3 visit with ok toggling outside MEMWAIT
    g_stp0 = 1'b1;
    gcyc("g_s1", ev(P0, S1P)); g_stp0 = 1'b0;
    gcyc("g_s2", ev(P0, S2P));
    gcyc("g_got", ev(P0, GP)); g_ep3 = 1'b1;
    gcyc("g_p3_entry", ev(P3, N)); g_ep3 = 1'b0; g_ok = 1'b1;
    gcyc("g_p3_s1", ev(P3, S1P)); g_ok = 1'b0;
    gcyc("g_p3_s2", ev(P3, S2P)); g_ok = 1'b1;
    gcyc("g_p3_got", ev(P3, GP)); g_ok = 1'b0;
    gcyc("g_p0", ev(P0, N));

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/state_seq.md
STATE_SEQ -- requirements
Module: state_seq

Interface
REQ-001 Parameter STROB_GAP, default 1, idle cycles between strob1 and strob2 within a state (range 0..7).
REQ-002 Parameter ALARM_TICKS, default 16, cycles a memory state waits for ok before alarm (range 2..255).
REQ-003 __clk  in  1  single system clock; all state changes on rising edge.
REQ-004 clo  in  1  reset; synchronous and active-high.
REQ-005 ep0, ep1, ep2, ep3, ep4, ep5  in  1 each  enable transition to state P0..P5.
REQ-006 ek1, ek2  in  1 each  enable transition to control-panel state K1, K2.
REQ-007 ewx  in  1  enable transition to execute state WX.
REQ-008 stp0  in  1  start a timing cycle while in P0.
REQ-009 ok  in  1  memory transfer acknowledge.
REQ-010 p0, p1, p2, p3, p4, p5, k1, k2, wx  out  1 each  one-hot current state.
REQ-011 strob1, strob2, got  out  1 each  single-cycle timing pulses.
REQ-012 mem_rq  out  1  memory request, held while waiting for ok.
REQ-013 alarm  out  1  single-cycle memory timeout pulse.

Function
REQ-014 Exactly one state output SHALL be high in every cycle.
REQ-015 Each state SHALL run the phase sequence ENTRY -> [MEMWAIT] -> S1 -> GAP (STROB_GAP cycles, skipped if 0) -> S2 -> GOT -> next state's ENTRY.
REQ-016 strob1 SHALL be high only in S1, strob2 only in S2, got only in GOT, each exactly one cycle per state visit.
REQ-017 Non-memory states (P3, P4, P5, K1, K2, WX) SHALL go ENTRY -> S1 in one cycle; with STROB_GAP=1, strob1 at entry+1, strob2 at entry+3, got at entry+4, next state at entry+5.
REQ-018 Memory states P1 and P2 SHALL enter MEMWAIT from ENTRY with mem_rq high from entry+1 until the cycle ok is sampled high, then S1 follows the next cycle and mem_rq drops there.
REQ-019 ok sampled outside MEMWAIT SHALL be ignored.
REQ-020 If MEMWAIT lasts ALARM_TICKS cycles without ok, alarm SHALL pulse in the next cycle, mem_rq drop, S1/S2 be skipped, GOT follow, and next state be forced to P0 regardless of enables.
REQ-021 ok high in the last MEMWAIT cycle before timeout SHALL win: no alarm, normal S1.
REQ-022 In P0, ENTRY SHALL hold (no pulses) while stp0 is low; S1 follows the cycle after stp0 is sampled high.
REQ-023 Next state SHALL be selected from enables sampled in GOT with fixed priority ek2 > ek1 > ep0 > ep5 > ep4 > ep3 > ep2 > ep1 > ewx.
REQ-024 If no enable is high in GOT, next state SHALL be P0.
REQ-025 Re-entering the same state SHALL restart its phase sequence from ENTRY.
REQ-026 Enables SHALL be ignored outside GOT.
REQ-027 The memory wait counter SHALL be 8 bits, cleared at ENTRY, saturating, never wrapping.

Reset
REQ-028 clo high at any clock edge SHALL force state P0, phase ENTRY, counters zero, on the next cycle, overriding any phase including MEMWAIT and GOT.
REQ-029 After reset: p0=1; p1..p5, k1, k2, wx, strob1, strob2, got, mem_rq, alarm all 0.
REQ-030 clo held high SHALL keep outputs at reset values; stp0 is ignored until the cycle after clo falls.

Verification
REQ-031 clo pulse mid-P4 S2 -> next cycle p0=1, strob2=0, all pulses 0; stp0 low 10 cycles -> no strob1.
REQ-032 P0, stp0=1 at cycle 0, ep1=1 in GOT -> strob1 c1, strob2 c3, got c4, p1=1 c5, mem_rq c6..; ok at c8 -> mem_rq low c9, strob1 c9.
REQ-033 P1 with ok never asserted, ALARM_TICKS=16 -> mem_rq 16 cycles, alarm 1 cycle, no strob1/strob2, got, then p0=1 even with ep3=1.
REQ-034 GOT with ep1, ep4, ewx, ek1 all high -> k1=1 next; repeat with ep1, ewx only -> p1=1; nothing high -> p0=1.
REQ-035 STROB_GAP=0 in P3 -> strob1 entry+1, strob2 entry+2, got entry+3; ok pulses during P3 -> ignored, mem_rq stays 0.
REQ-036 Every cycle of all runs -> one-hot state check and each pulse at most once per visit.
